// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared encodings for the SDRAM port arbiter.
//   owner_t : which requester currently holds the controller slot
//   state_t : arbiter FSM states
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_VID   = 2'd1,
    OWN_WR    = 2'd2,
    OWN_CACHE = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// sdram_arb_prio: combinational winner select (video > write > cache) with an
// optional aging override that forces the cache to win after AGE_LIMIT lost
// arbitrations. The age counter only exists when SDRAM_ARB_AGING_EN is defined.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset (age counter only)
//   arb_en               arbiter is in IDLE and will act on grant this cycle
//   vid_req/wr_req/cache_req  request levels
//   grant                winning requester, OWN_NONE when nobody requests
import sdram_arb_pkg::*;

module sdram_arb_prio #(
  parameter int AGE_LIMIT = 8
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   arb_en,
  input  logic   vid_req,
  input  logic   wr_req,
  input  logic   cache_req,
  output owner_t grant
);

  logic force_cache;

`ifdef SDRAM_ARB_AGING_EN
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_d, age_q;

  assign force_cache = cache_req && (age_q >= AGE_MAX);

  // Count only arbitrations the cache actually lost; saturate at the limit.
  always_comb begin
    age_d = age_q;
    if (arb_en) begin
      if (grant == OWN_CACHE) begin
        age_d = '0;
      end else if (cache_req && (age_q < AGE_MAX)) begin
        age_d = age_q + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  logic unused_aging;
  assign unused_aging = &{1'b0, clk, reset_n, arb_en};
  assign force_cache  = 1'b0;
`endif

  always_comb begin
    grant = OWN_NONE;
    if (force_cache)    grant = OWN_CACHE;
    else if (vid_req)   grant = OWN_VID;
    else if (wr_req)    grant = OWN_WR;
    else if (cache_req) grant = OWN_CACHE;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller command slot between the
// video fetch DMA, the CPU write-through path and the cache line-fill port.
// Winner is latched in IDLE, the command is held in ISSUE until ctrl_ack, and
// read beats are counted in RDATA and forwarded (registered) to the owner.
// Optional build macro: SDRAM_ARB_AGING_EN (cache aging override).
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   vid_req/vid_addr -> vid_valid/vid_data   video burst requester
//   wr_req/wr_addr/wr_data/wr_be -> wr_ack    single-word write requester
//   cache_req/cache_addr -> cache_fill/cache_data  cache line-fill requester
//   ctrl_req/addr/we/be/wdata, ctrl_ack/rvalid/rdata  controller interface
//   owner                                current owner (owner_t encoding)
import sdram_arb_pkg::*;

module sdram_port_arbiter #(
  parameter int ADDR_W    = 25,
  parameter int BURST_LEN = 4,
  parameter int AGE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [15:0]       vid_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_fill,
  output logic [15:0]       cache_data,
  output logic              ctrl_req,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic              ctrl_we,
  output logic [1:0]        ctrl_be,
  output logic [15:0]       ctrl_wdata,
  input  logic              ctrl_ack,
  input  logic              ctrl_rvalid,
  input  logic [15:0]       ctrl_rdata,
  output logic [1:0]        owner
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state_d, state_q;
  owner_t              owner_d, owner_q;
  logic [BEAT_W-1:0]   beat_d, beat_q;
  logic                ctrl_req_d, ctrl_req_q;
  logic [ADDR_W-1:0]   ctrl_addr_d, ctrl_addr_q;
  logic                ctrl_we_d, ctrl_we_q;
  logic [1:0]          ctrl_be_d, ctrl_be_q;
  logic [15:0]         ctrl_wdata_d, ctrl_wdata_q;
  logic                wr_ack_d, wr_ack_q;
  logic                vid_valid_d, vid_valid_q;
  logic [15:0]         vid_data_d, vid_data_q;
  logic                cache_fill_d, cache_fill_q;
  logic [15:0]         cache_data_d, cache_data_q;

  owner_t              grant;
  logic                wr_req_arb;
  logic                beat_take;
  logic [BEAT_W-1:0]   beat_idx;

  // The writer only drops wr_req after seeing wr_ack, so the request is still
  // high in the IDLE cycle that follows the ack; mask it to avoid a repeat.
  assign wr_req_arb = wr_req && !wr_ack_q;

  sdram_arb_prio #(
    .AGE_LIMIT (AGE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .arb_en    (state_q == IDLE),
    .vid_req   (vid_req),
    .wr_req    (wr_req_arb),
    .cache_req (cache_req),
    .grant     (grant)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_d       = beat_q;
    ctrl_req_d   = ctrl_req_q;
    ctrl_addr_d  = ctrl_addr_q;
    ctrl_we_d    = ctrl_we_q;
    ctrl_be_d    = ctrl_be_q;
    ctrl_wdata_d = ctrl_wdata_q;
    wr_ack_d     = 1'b0;
    vid_valid_d  = 1'b0;
    vid_data_d   = vid_data_q;
    cache_fill_d = 1'b0;
    cache_data_d = cache_data_q;
    beat_take    = 1'b0;
    beat_idx     = beat_q;

    case (state_q)
      IDLE: begin
        if (grant != OWN_NONE) begin
          state_d      = ISSUE;
          owner_d      = grant;
          ctrl_req_d   = 1'b1;
          ctrl_we_d    = 1'b0;
          ctrl_be_d    = 2'b00;
          ctrl_wdata_d = '0;
          case (grant)
            OWN_VID:   ctrl_addr_d = vid_addr;
            OWN_WR: begin
              ctrl_addr_d  = wr_addr;
              ctrl_we_d    = 1'b1;
              ctrl_be_d    = wr_be;
              ctrl_wdata_d = wr_data;
            end
            default:   ctrl_addr_d = cache_addr;
          endcase
        end
      end
      ISSUE: begin
        if (ctrl_ack) begin
          ctrl_req_d = 1'b0;
          if (ctrl_we_q) begin
            wr_ack_d = 1'b1;
            state_d  = IDLE;
            owner_d  = OWN_NONE;
          end else begin
            state_d   = RDATA;
            beat_d    = '0;
            beat_idx  = '0;
            // A beat arriving with the ack is beat 0.
            beat_take = ctrl_rvalid;
          end
        end
      end
      RDATA: begin
        beat_take = ctrl_rvalid;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    if (beat_take) begin
      if (owner_q == OWN_VID) begin
        vid_valid_d = 1'b1;
        vid_data_d  = ctrl_rdata;
      end
      if (owner_q == OWN_CACHE) begin
        cache_fill_d = (beat_idx == '0);
        cache_data_d = ctrl_rdata;
      end
      beat_d = beat_idx + BEAT_W'(1);
      if (beat_idx == LAST_BEAT) begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      beat_q       <= '0;
      ctrl_req_q   <= 1'b0;
      ctrl_addr_q  <= '0;
      ctrl_we_q    <= 1'b0;
      ctrl_be_q    <= 2'b00;
      ctrl_wdata_q <= '0;
      wr_ack_q     <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      cache_fill_q <= 1'b0;
      cache_data_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_q       <= beat_d;
      ctrl_req_q   <= ctrl_req_d;
      ctrl_addr_q  <= ctrl_addr_d;
      ctrl_we_q    <= ctrl_we_d;
      ctrl_be_q    <= ctrl_be_d;
      ctrl_wdata_q <= ctrl_wdata_d;
      wr_ack_q     <= wr_ack_d;
      vid_valid_q  <= vid_valid_d;
      vid_data_q   <= vid_data_d;
      cache_fill_q <= cache_fill_d;
      cache_data_q <= cache_data_d;
    end
  end

  assign ctrl_req   = ctrl_req_q;
  assign ctrl_addr  = ctrl_addr_q;
  assign ctrl_we    = ctrl_we_q;
  assign ctrl_be    = ctrl_be_q;
  assign ctrl_wdata = ctrl_wdata_q;
  assign wr_ack     = wr_ack_q;
  assign vid_valid  = vid_valid_q;
  assign vid_data   = vid_data_q;
  assign cache_fill = cache_fill_q;
  assign cache_data = cache_data_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (ADDR_W=25, BURST_LEN=4, AGE_LIMIT=8).
// The aging scenario is only exercised when SDRAM_ARB_AGING_EN is defined.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [15:0]       vid_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;
  logic              wr_ack;
  logic              cache_req;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_fill;
  logic [15:0]       cache_data;
  logic              ctrl_req;
  logic [ADDR_W-1:0] ctrl_addr;
  logic              ctrl_we;
  logic [1:0]        ctrl_be;
  logic [15:0]       ctrl_wdata;
  logic              ctrl_ack;
  logic              ctrl_rvalid;
  logic [15:0]       ctrl_rdata;
  logic [1:0]        owner;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (4),
    .AGE_LIMIT (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_valid   (vid_valid),
    .vid_data    (vid_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_ack      (wr_ack),
    .cache_req   (cache_req),
    .cache_addr  (cache_addr),
    .cache_fill  (cache_fill),
    .cache_data  (cache_data),
    .ctrl_req    (ctrl_req),
    .ctrl_addr   (ctrl_addr),
    .ctrl_we     (ctrl_we),
    .ctrl_be     (ctrl_be),
    .ctrl_wdata  (ctrl_wdata),
    .ctrl_ack    (ctrl_ack),
    .ctrl_rvalid (ctrl_rvalid),
    .ctrl_rdata  (ctrl_rdata),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    vid_req     = 1'b0;
    vid_addr    = '0;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_be       = '0;
    cache_req   = 1'b0;
    cache_addr  = '0;
    ctrl_ack    = 1'b0;
    ctrl_rvalid = 1'b0;
    ctrl_rdata  = '0;

    // ---- reset state ----
    tick(); tick(); tick();
    chk("rst_ctrl_req", 32'(ctrl_req), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cache_fill", 32'(cache_fill), 0);
    chk("rst_ctrl_addr", 32'(ctrl_addr), 0);
    chk("rst_ctrl_we", 32'(ctrl_we), 0);
    chk("rst_cache_data", 32'(cache_data), 0);
    reset_n = 1'b1;
    tick();

    // ---- cache fill alone, ack after 2 cycles ----
    cache_req  = 1'b1;
    cache_addr = 25'h000123;
    tick();
    chk("c1_ctrl_req", 32'(ctrl_req), 1);
    chk("c1_owner", 32'(owner), 3);
    chk("c1_addr", 32'(ctrl_addr), 32'h123);
    chk("c1_we", 32'(ctrl_we), 0);
    tick();
    chk("c1_req_held", 32'(ctrl_req), 1);
    chk("c1_addr_held", 32'(ctrl_addr), 32'h123);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    chk("c1_req_drop", 32'(ctrl_req), 0);
    chk("c1_no_fill_yet", 32'(cache_fill), 0);
    for (int i = 0; i < 4; i++) begin
      ctrl_rvalid = 1'b1;
      ctrl_rdata  = 16'(16'hA0A0 + i * 16'h0101);
      tick();
      if (i == 0) cache_req = 1'b0;
      chk("c1_fill", 32'(cache_fill), (i == 0) ? 1 : 0);
      chk("c1_data", 32'(cache_data), 32'(16'(16'hA0A0 + i * 16'h0101)));
      chk("c1_owner_beat", 32'(owner), (i == 3) ? 0 : 3);
      chk("c1_vid_quiet", 32'(vid_valid), 0);
    end
    ctrl_rvalid = 1'b0;
    tick();
    chk("c1_idle_req", 32'(ctrl_req), 0);
    chk("c1_idle_fill", 32'(cache_fill), 0);

    // ---- single write, be=01 ----
    wr_req  = 1'b1;
    wr_addr = 25'h0ABCDE;
    wr_data = 16'hBEEF;
    wr_be   = 2'b01;
    tick();
    chk("w_ctrl_req", 32'(ctrl_req), 1);
    chk("w_we", 32'(ctrl_we), 1);
    chk("w_be", 32'(ctrl_be), 32'h1);
    chk("w_wdata", 32'(ctrl_wdata), 32'hBEEF);
    chk("w_addr", 32'(ctrl_addr), 32'h0ABCDE);
    chk("w_owner", 32'(owner), 2);
    chk("w_ack_early", 32'(wr_ack), 0);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    chk("w_ack_pulse", 32'(wr_ack), 1);
    chk("w_req_drop", 32'(ctrl_req), 0);
    chk("w_owner_none", 32'(owner), 0);
    // Writer still holds wr_req through the ack cycle.
    tick();
    wr_req = 1'b0;
    chk("w_ack_single", 32'(wr_ack), 0);
    chk("w_no_repeat", 32'(ctrl_req), 0);
    chk("w_vid_quiet", 32'(vid_valid), 0);
    chk("w_cache_quiet", 32'(cache_fill), 0);

    // ---- stray rvalid in IDLE is discarded ----
    ctrl_rvalid = 1'b1;
    ctrl_rdata  = 16'h5555;
    tick();
    ctrl_rvalid = 1'b0;
    chk("stray_vid", 32'(vid_valid), 0);
    chk("stray_fill", 32'(cache_fill), 0);
    chk("stray_data", 32'(cache_data), 32'hA3A3);

    // ---- simultaneous requests: video, then write, then cache ----
    vid_req    = 1'b1; vid_addr   = 25'h000100;
    wr_req     = 1'b1; wr_addr    = 25'h000200; wr_data = 16'h1234; wr_be = 2'b11;
    cache_req  = 1'b1; cache_addr = 25'h000300;
    tick();
    vid_req = 1'b0;
    chk("p_owner_vid", 32'(owner), 1);
    chk("p_addr_vid", 32'(ctrl_addr), 32'h100);
    // ack together with beat 0
    ctrl_ack    = 1'b1;
    ctrl_rvalid = 1'b1;
    ctrl_rdata  = 16'hC000;
    tick();
    ctrl_ack = 1'b0;
    chk("p_v0_valid", 32'(vid_valid), 1);
    chk("p_v0_data", 32'(vid_data), 32'hC000);
    for (int i = 1; i < 4; i++) begin
      ctrl_rdata = 16'(16'hC000 + i);
      tick();
      chk("p_v_valid", 32'(vid_valid), 1);
      chk("p_v_data", 32'(vid_data), 32'(16'hC000 + i));
    end
    ctrl_rvalid = 1'b0;
    chk("p_v_done_owner", 32'(owner), 0);
    tick();
    chk("p_v_beats4", 32'(vid_valid), 0);
    chk("p_owner_wr", 32'(owner), 2);
    chk("p_addr_wr", 32'(ctrl_addr), 32'h200);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    chk("p_wr_ack", 32'(wr_ack), 1);
    tick();
    wr_req = 1'b0;
    chk("p_owner_cache", 32'(owner), 3);
    chk("p_addr_cache", 32'(ctrl_addr), 32'h300);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctrl_rvalid = 1'b1;
      ctrl_rdata  = 16'(16'hD000 + i);
      tick();
      if (i == 0) cache_req = 1'b0;
      chk("p_c_fill", 32'(cache_fill), (i == 0) ? 1 : 0);
      chk("p_c_data", 32'(cache_data), 32'(16'hD000 + i));
    end
    ctrl_rvalid = 1'b0;
    chk("p_c_owner_none", 32'(owner), 0);
    tick();

    // ---- reset during beat 2 of a cache fill ----
    cache_req  = 1'b1;
    cache_addr = 25'h000040;
    tick();
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack    = 1'b0;
    ctrl_rvalid = 1'b1;
    ctrl_rdata  = 16'hE000;
    tick();
    cache_req = 1'b0;
    chk("r_fill0", 32'(cache_fill), 1);
    ctrl_rdata = 16'hE001;
    tick();
    ctrl_rdata = 16'hE002;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("r_owner", 32'(owner), 0);
    chk("r_cache_data", 32'(cache_data), 0);
    chk("r_ctrl_addr", 32'(ctrl_addr), 0);
    chk("r_fill", 32'(cache_fill), 0);
    ctrl_rdata = 16'hE003;
    tick();
    ctrl_rvalid = 1'b0;
    chk("r_trail_fill", 32'(cache_fill), 0);
    chk("r_trail_data", 32'(cache_data), 0);
    chk("r_trail_req", 32'(ctrl_req), 0);
    cache_req  = 1'b1;
    cache_addr = 25'h000050;
    tick();
    chk("r2_owner", 32'(owner), 3);
    chk("r2_addr", 32'(ctrl_addr), 32'h50);
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctrl_rvalid = 1'b1;
      ctrl_rdata  = 16'(16'hF000 + i);
      tick();
      if (i == 0) cache_req = 1'b0;
      chk("r2_fill", 32'(cache_fill), (i == 0) ? 1 : 0);
      chk("r2_data", 32'(cache_data), 32'(16'hF000 + i));
    end
    ctrl_rvalid = 1'b0;
    chk("r2_owner_none", 32'(owner), 0);
    tick();

`ifdef SDRAM_ARB_AGING_EN
    // ---- aging: continuous video plus cache; cache wins 9th arbitration ----
    vid_req    = 1'b1; vid_addr   = 25'h000700;
    cache_req  = 1'b1; cache_addr = 25'h000900;
    for (int a = 0; a < 8; a++) begin
      tick();
      chk("age_vid_win", 32'(owner), 1);
      ctrl_ack    = 1'b1;
      ctrl_rvalid = 1'b1;
      tick();
      ctrl_ack = 1'b0;
      tick(); tick(); tick();
      ctrl_rvalid = 1'b0;
    end
    tick();
    chk("age_cache_win", 32'(owner), 3);
    chk("age_cache_addr", 32'(ctrl_addr), 32'h900);
    chk("age_cleared", 32'(dut.u_prio.age_q), 0);
    vid_req = 1'b0;
    ctrl_ack = 1'b1;
    tick();
    ctrl_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctrl_rvalid = 1'b1;
      ctrl_rdata  = 16'(16'h9000 + i);
      tick();
      if (i == 0) cache_req = 1'b0;
      chk("age_fill", 32'(cache_fill), (i == 0) ? 1 : 0);
    end
    ctrl_rvalid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single SDRAM controller command/data slot between three requesters: the two-way cache line-fill port, the CPU write-through path and the video fetch DMA. It selects one requester by fixed priority with optional aging, issues that requester's command, and routes the returned burst. For the cache, the routed burst matches the fill protocol: one `fill` strobe on the first word, then the remaining words on consecutive cycles.

## Interface
- `ADDR_W`, default 25: word-address width (byte address bits 25:1).
- `BURST_LEN`, default 4: read beats per burst; must be a power of two.
- `AGE_LIMIT`, default 8: lost arbitrations before the cache is forced to win.
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `vid_req`  in  1  video burst request, level; sampled in IDLE only.
- `vid_addr`  in  ADDR_W  video burst start word address.
- `vid_valid`  out  1  video read beat valid.
- `vid_data`  out  16  video read beat.
- `wr_req`  in  1  single-word write request, held until `wr_ack`.
- `wr_addr`  in  ADDR_W  write word address.
- `wr_data`  in  16  write data.
- `wr_be`  in  2  byte enables: [1] upper byte, [0] lower byte.
- `wr_ack`  out  1  one-cycle pulse when the controller accepts the write.
- `cache_req`  in  1  line-fill request, level.
- `cache_addr`  in  ADDR_W  critical-word address.
- `cache_fill`  out  1  one-cycle strobe on the first fill word.
- `cache_data`  out  16  fill word.
- `ctrl_req`  out  1  command valid to controller.
- `ctrl_addr`  out  ADDR_W  command address.
- `ctrl_we`  out  1  1 = write.
- `ctrl_be`  out  2  write byte enables.
- `ctrl_wdata`  out  16  write data.
- `ctrl_ack`  in  1  command accepted, one-cycle pulse.
- `ctrl_rvalid`  in  1  read beat valid.
- `ctrl_rdata`  in  16  read beat.
- `owner`  out  2  current owner (OWN_* encoding).

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `ctrl_req` high, waiting for `ctrl_ack`.
  - RDATA: counting read beats.
- IDLE, with any request present:
  - Latch the winner's address, data, byte enables and `ctrl_we`; set `owner`; go to ISSUE.
  - Priority: video > write > cache. Exception: the cache wins when the aging override is active.
- ISSUE:
  - Hold `ctrl_req` and all command fields stable until `ctrl_ack`.
  - On `ctrl_ack` for a write: pulse `wr_ack`, return to IDLE.
  - On `ctrl_ack` for a read: go to RDATA with the beat counter at 0.
  - A `ctrl_rvalid` in the same cycle as `ctrl_ack` counts as beat 0.
- RDATA:
  - Each `ctrl_rvalid` increments the beat counter (log2(BURST_LEN)+1 bits) and is forwarded to the owner.
  - On beat BURST_LEN-1, return to IDLE and set `owner` to OWN_NONE.
- Cache routing:
  - `cache_fill` = 1 only on beat 0.
  - `cache_data` carries every beat; no data is lost after the strobe.
  - The controller delivers the critical word first and wraps within the line.
  - Beats must be consecutive, because the cache cannot stall.
- `ctrl_rvalid` outside ISSUE/RDATA is discarded.
- Requests deasserting while not owned are ignored.
- `cache_req` can still be high for up to 1 cycle after `cache_fill`. This is harmless: the burst outlasts it.
- Reset mid-burst:
  - State goes to IDLE and all outputs clear.
  - Trailing controller beats are discarded.
  - No `wr_ack` or `cache_fill` is produced for the aborted command.

## Timing
- Reset values: `ctrl_req`, `ctrl_we`, `wr_ack`, `vid_valid`, `cache_fill` = 0; `ctrl_addr`, `ctrl_be`, `ctrl_wdata`, `vid_data`, `cache_data` = 0; `owner` = OWN_NONE; beat counter and age counter = 0.
- All outputs are registered.
- `ctrl_req` rises 1 cycle after a request is seen in IDLE.
- `wr_ack` is 1 cycle after `ctrl_ack`.
- Read beats reach the owner 1 cycle after `ctrl_rvalid`.
- Minimum write turnaround: 3 cycles, request to next arbitration.

## Configuration
- `SDRAM_ARB_AGING_EN` defined:
  - The age counter increments each time the cache is refused while `cache_req` = 1.
  - At AGE_LIMIT the cache wins the next arbitration.
  - The counter clears on every cache grant.
- `SDRAM_ARB_AGING_EN` undefined: pure fixed priority, and no age counter is built.

## Structure
- Package `sdram_arb_pkg`:
  - Owner encoding: OWN_NONE=0, OWN_VID=1, OWN_WR=2, OWN_CACHE=3.
  - State encoding: IDLE, ISSUE, RDATA.
- Sub-module `sdram_arb_prio`: combinational winner select plus the aging counter, which is conditional on `SDRAM_ARB_AGING_EN`.
- FSM, latches and routing stay in the top module.

## Test plan
- Cache request alone, address 0x000123, controller acks after 2 cycles, beats A0..A3 → `cache_fill` high with A0 only; A1..A3 on the next 3 cycles; `owner` returns to 0.
- Write request with `wr_be`=01, data 0xBEEF → `ctrl_we`=1, `ctrl_be`=01, `ctrl_wdata`=0xBEEF; `wr_ack` is exactly one pulse; no read outputs toggle.
- Video, write and cache requests in the same cycle → grant order is video, write, cache.
- Aging enabled, AGE_LIMIT=8, video requesting continuously plus a cache request → cache granted on the 9th arbitration; age counter reads 0 afterwards.
- `ctrl_rvalid` in the same cycle as `ctrl_ack` → counted as beat 0; exactly BURST_LEN beats forwarded.
- `reset_n` low during beat 2 of a cache fill → all outputs 0 next cycle; remaining beats ignored; next cache request performs a fresh fill.
